// File: rtl/moore_seq_pkg.sv
// Shared helpers for the serial pattern detector: state-width sizing and the
// KMP-style next-state function evaluated at elaboration time.
package moore_seq_pkg;

    localparam int MIN_PATTERN_W = 2;
    localparam int MAX_PATTERN_W = 32;

    function automatic int state_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic bit pattern_w_ok(input int width);
        return (width >= MIN_PATTERN_W) && (width <= MAX_PATTERN_W);
    endfunction

    // Length of the longest suffix of (prefix(k) followed by b) that is also a
    // prefix of the pattern. The MSB of the pattern is the first bit received.
    function automatic int seq_next(input int k, input logic b,
                                    input logic [31:0] pattern, input int width);
        int   len;
        int   best;
        int   pos;
        logic sym;
        logic hit;
        len  = k + 1;
        best = 0;
        for (int j = 1; j <= width; j++) begin
            if (j <= len) begin
                hit = 1'b1;
                for (int i = 0; i < j; i++) begin
                    pos = len - j + i;
                    sym = (pos == k) ? b : pattern[width-1-pos];
                    if (sym != pattern[width-1-i]) begin
                        hit = 1'b0;
                    end
                end
                if (hit) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: table-driven prefix-tracking FSM with a
// registered detect flag and a saturating match counter.
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in,
    input  logic                          in_valid,
    input  logic                          clear,
    output logic                          out,
    output logic [state_w(PATTERN_W)-1:0] state_o,
    output logic [CNT_W-1:0]              match_count
);

    localparam int SW = state_w(PATTERN_W);
    localparam int NS = 1 << SW;

    localparam logic [SW-1:0] S_0   = '0;
    localparam logic [SW-1:0] S_DET = SW'(PATTERN_W);

    generate
        if (!pattern_w_ok(PATTERN_W)) begin : g_bad_width
            $error("moore_seq_detector: PATTERN_W must be in 2..32");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("moore_seq_detector: CNT_W must be at least 1");
        end
    endgenerate

    logic [SW-1:0] next0 [NS];
    logic [SW-1:0] next1 [NS];

    // Unreachable encodings above S_DET fall back to S_0; with OVERLAP=0 the
    // detect state behaves like S_0 so no bits of the hit are reused.
    generate
        for (genvar k = 0; k < NS; k++) begin : g_next
            localparam int SRC = (k > PATTERN_W) ? 0 :
                                 ((k == PATTERN_W) && !OVERLAP) ? 0 : k;
            localparam logic [SW-1:0] N0 = (k > PATTERN_W) ? S_0 :
                SW'(seq_next(SRC, 1'b0, 32'(PATTERN), PATTERN_W));
            localparam logic [SW-1:0] N1 = (k > PATTERN_W) ? S_0 :
                SW'(seq_next(SRC, 1'b1, 32'(PATTERN), PATTERN_W));
            assign next0[k] = N0;
            assign next1[k] = N1;
        end
    endgenerate

    logic [SW-1:0] state;
    logic [SW-1:0] state_next;
    logic          hit;

    assign state_next = in ? next1[state] : next0[state];
    assign hit        = in_valid && (state_next == S_DET);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_0;
        end else if (in_valid) begin
            state <= state_next;
        end
    end

    assign out     = (state == S_DET);
    assign state_o = state;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_count (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (clear),
        .count (match_count)
    );

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: default, non-overlapping, 2-bit
// counter and all-ones variants driven from one shared stimulus stream.
module tb_moore_seq_detector;

    logic clk = 1'b0;
    logic reset, in, in_valid, clear;

    logic       out_a, out_n, out_c, out_o;
    logic [2:0] st_a, st_n, st_c;
    logic [1:0] st_o;
    logic [7:0] cnt_a, cnt_n, cnt_o;
    logic [1:0] cnt_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    moore_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out_a), .state_o(st_a), .match_count(cnt_a));

    moore_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_n (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out_n), .state_o(st_n), .match_count(cnt_n));

    moore_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out_c), .state_o(st_c), .match_count(cnt_c));

    moore_seq_detector #(.PATTERN_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(8)) dut_o (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out_o), .state_o(st_o), .match_count(cnt_o));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic b, input logic v, input logic c, input logic r);
        @(negedge clk);
        in       = b;
        in_valid = v;
        clear    = c;
        reset    = r;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] pat;
    logic [2:0] exp_st [4];
    logic [1:0] exp_c2 [5];

    initial begin
        reset = 1'b1; in = 1'b0; in_valid = 1'b0; clear = 1'b0;
        pat = 4'b1011;
        exp_st[0] = 3'd1; exp_st[1] = 3'd2; exp_st[2] = 3'd3; exp_st[3] = 3'd4;
        exp_c2[0] = 2'd1; exp_c2[1] = 2'd2; exp_c2[2] = 2'd3; exp_c2[3] = 2'd3; exp_c2[4] = 2'd3;

        // Reset for two cycles
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_out", 32'(out_a), 0);
        check("rst_state", 32'(st_a), 0);
        check("rst_count", 32'(cnt_a), 0);
        check("rst_count_c2", 32'(cnt_c), 0);

        // Single detect of 1011
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t1_st1", 32'(st_a), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_st2", 32'(st_a), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t1_st3", 32'(st_a), 3);
        check("t1_out_early", 32'(out_a), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t1_out", 32'(out_a), 1);
        check("t1_state", 32'(st_a), 4);
        check("t1_count", 32'(cnt_a), 1);
        check("t1_count_novl", 32'(cnt_n), 1);

        // Overlapping vs non-overlapping: 1,0,1,1,0,1,1
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_rst_count", 32'(cnt_a), 0);
        for (int i = 3; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
        check("t2_first_out", 32'(out_a), 1);
        check("t2_first_out_novl", 32'(out_n), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_ovl_st_after0", 32'(st_a), 2);
        check("t2_novl_st_after0", 32'(st_n), 0);
        check("t2_out_drop", 32'(out_a), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_ovl_st_after1", 32'(st_a), 3);
        check("t2_novl_st_after1", 32'(st_n), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_ovl_second_out", 32'(out_a), 1);
        check("t2_ovl_count", 32'(cnt_a), 2);
        check("t2_novl_out", 32'(out_n), 0);
        check("t2_novl_count", 32'(cnt_n), 1);
        check("t2_c2_count", 32'(cnt_c), 2);

        // Idle gaps of 3 cycles between valid bits, junk on 'in' while idle
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(pat[3-i], 1'b1, 1'b0, 1'b0);
            for (int g = 0; g < 3; g++) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                check($sformatf("t3_hold_b%0d_g%0d", i, g), 32'(st_a), 32'(exp_st[i]));
            end
        end
        check("t3_out_held", 32'(out_a), 1);
        check("t3_count", 32'(cnt_a), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_out_after_valid", 32'(out_a), 0);
        check("t3_state_after_valid", 32'(st_a), 2);

        // Saturation of a 2-bit counter over five back-to-back detects
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 5; r++) begin
            for (int i = 3; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
            check($sformatf("t4_c2_count_%0d", r), 32'(cnt_c), 32'(exp_c2[r]));
            check($sformatf("t4_count_%0d", r), 32'(cnt_a), 32'(r + 1));
            check($sformatf("t4_novl_count_%0d", r), 32'(cnt_n), 32'(r + 1));
        end

        // Clear coincident with a detect: clear wins, state still advances
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t6_out", 32'(out_a), 1);
        check("t6_count_cleared", 32'(cnt_a), 0);
        check("t6_c2_cleared", 32'(cnt_c), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_next_out", 32'(out_a), 1);
        check("t6_next_count", 32'(cnt_a), 1);
        check("t6_novl_state", 32'(st_n), 1);
        check("t6_novl_count", 32'(cnt_n), 0);

        // Reset mid-pattern (with in_valid and clear also high) discards progress
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_reset_state", 32'(st_a), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_out", 32'(out_a), 0);
        check("t5_state", 32'(st_a), 1);
        check("t5_count", 32'(cnt_a), 0);

        // All-ones pattern: S_W -> S_W counts every extra '1'
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("ones_out", 32'(out_o), 1);
        check("ones_count1", 32'(cnt_o), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("ones_stay", 32'(st_o), 3);
        check("ones_count2", 32'(cnt_o), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("ones_count3", 32'(cnt_o), 3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("ones_break", 32'(st_o), 0);
        check("ones_break_count", 32'(cnt_o), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
